bf_tape_master: RTL and testbench

BF_TAPE_MASTER -- requirements
Module: bf_tape_master

---
 rtl/bf_tape_master.sv | 125 ++++++++++++
 tb/tb_bf_tape_master.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bf_tape_master.sv
// Tape-head controller for a byte tape: a pointer plus read/modify/write of the current cell. Latency: 2 cycles (LEFT/RIGHT/LOAD/STORE) or 3 cycles (INC/DEC) from accept to resp_valid; reserved ops respond after 1.
// Backpressure: each busy cycle on a write and each missing-rvalid cycle on a read stretches the op by one cycle; cmd_ready is high only in IDLE.
`timescale 1ns/1ps
module bf_tape_master #(
  parameter int logsize = 8
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [7:0]         cmd_data,
  output logic               resp_valid,
  output logic [7:0]         resp_data,
  output logic               resp_zero,
  output logic [logsize-1:0] ptr,
  output logic [logsize-1:0] addr,
  output logic [7:0]         wdata,
  output logic               wselect,
  output logic               doit,
  input  logic               busy,
  input  logic               rvalid,
  input  logic [7:0]         rdata
);

  localparam logic [2:0] OP_LEFT  = 3'd0;
  localparam logic [2:0] OP_RIGHT = 3'd1;
  localparam logic [2:0] OP_INC   = 3'd2;
  localparam logic [2:0] OP_DEC   = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t     state;
  logic [2:0] op_q;

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state      <= IDLE;
      op_q       <= 3'd0;
      ptr        <= '0;
      addr       <= '0;
      wdata      <= 8'h00;
      wselect    <= 1'b0;
      doit       <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= 8'h00;
      resp_zero  <= 1'b1;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            case (cmd_op)
              OP_LEFT: begin
                ptr     <= ptr - 1'b1;
                addr    <= ptr - 1'b1;
                wselect <= 1'b0;
                doit    <= 1'b1;
                state   <= RD;
              end
              OP_RIGHT: begin
                ptr     <= ptr + 1'b1;
                addr    <= ptr + 1'b1;
                wselect <= 1'b0;
                doit    <= 1'b1;
                state   <= RD;
              end
              OP_INC, OP_DEC, OP_LOAD: begin
                addr    <= ptr;
                wselect <= 1'b0;
                doit    <= 1'b1;
                state   <= RD;
              end
              OP_STORE: begin
                addr    <= ptr;
                wdata   <= cmd_data;
                wselect <= 1'b1;
                doit    <= 1'b1;
                state   <= WR;
              end
              default: begin
                // Reserved op: respond immediately with the previous result.
                resp_valid <= 1'b1;
                state      <= RESP;
              end
            endcase
          end
        end
        RD: begin
          if (rvalid) begin
            if (op_q == OP_INC || op_q == OP_DEC) begin
              // doit stays high; the write to the same cell follows directly.
              wdata   <= (op_q == OP_INC) ? rdata + 8'd1 : rdata - 8'd1;
              wselect <= 1'b1;
              state   <= WR;
            end else begin
              doit       <= 1'b0;
              resp_data  <= rdata;
              resp_zero  <= (rdata == 8'h00);
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end
        end
        WR: begin
          if (!busy) begin
            doit       <= 1'b0;
            wselect    <= 1'b0;
            resp_data  <= wdata;
            resp_zero  <= (wdata == 8'h00);
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_tape_master.sv
// Directed bench for bf_tape_master against a zero-wait byte tape model with a controllable busy line.
`timescale 1ns/1ps
module tb_bf_tape_master;

  logic       clk = 1'b0;
  logic       init_n, cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       resp_valid, resp_zero;
  logic [7:0] resp_data;
  logic [7:0] ptr, addr, wdata;
  logic       wselect, doit, busy, rvalid;
  logic [7:0] rdata;

  logic [7:0] mem [256] = '{default: 8'h00};
  int         wr_count = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  bf_tape_master #(.logsize(8)) dut (
    .clk(clk), .init_n(init_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_zero(resp_zero), .ptr(ptr), .addr(addr),
    .wdata(wdata), .wselect(wselect), .doit(doit), .busy(busy),
    .rvalid(rvalid), .rdata(rdata)
  );

  assign rvalid = doit & ~wselect & ~busy;
  assign rdata  = mem[addr];

  always @(posedge clk) begin
    if (doit && wselect && !busy) begin
      mem[addr] <= wdata;
      wr_count  <= wr_count + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one command and returns the cycles from acceptance edge to resp_valid.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] data, output int lat,
                         output logic [7:0] rd, output logic rz, output logic [7:0] rp);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'd0, 32'd1);
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd7;
    cmd_data  = ~data;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 40);
    if (!resp_valid) chk("resp_timeout", 32'd0, 32'd1);
    rd = resp_data;
    rz = resp_zero;
    rp = ptr;
    @(negedge clk);
    chk("resp_pulse", {31'd0, resp_valid}, 32'd0);
    chk("resp_hold", {24'd0, resp_data}, {24'd0, rd});
  endtask

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] exp_d;
    logic       exp_z;
    logic [3:0] exp_lat;
    logic [7:0] exp_ptr;
  } vec_t;

  vec_t vecs [18];

  initial begin
    int         lat, w, wc0;
    logic [7:0] rd, rp, a0, d0;
    logic       rz;

    vecs[0]  = '{3'd4, 8'h00, 8'h00, 1'b1, 4'd2, 8'h00};
    vecs[1]  = '{3'd2, 8'h00, 8'h01, 1'b0, 4'd3, 8'h00};
    vecs[2]  = '{3'd2, 8'h00, 8'h02, 1'b0, 4'd3, 8'h00};
    vecs[3]  = '{3'd2, 8'h00, 8'h03, 1'b0, 4'd3, 8'h00};
    vecs[4]  = '{3'd4, 8'h00, 8'h03, 1'b0, 4'd2, 8'h00};
    vecs[5]  = '{3'd5, 8'h5A, 8'h5A, 1'b0, 4'd2, 8'h00};
    vecs[6]  = '{3'd1, 8'h00, 8'h00, 1'b1, 4'd2, 8'h01};
    vecs[7]  = '{3'd5, 8'hA5, 8'hA5, 1'b0, 4'd2, 8'h01};
    vecs[8]  = '{3'd0, 8'h00, 8'h5A, 1'b0, 4'd2, 8'h00};
    vecs[9]  = '{3'd3, 8'h00, 8'h59, 1'b0, 4'd3, 8'h00};
    vecs[10] = '{3'd0, 8'h00, 8'h00, 1'b1, 4'd2, 8'hFF};
    vecs[11] = '{3'd3, 8'h00, 8'hFF, 1'b0, 4'd3, 8'hFF};
    vecs[12] = '{3'd1, 8'h00, 8'h59, 1'b0, 4'd2, 8'h00};
    vecs[13] = '{3'd6, 8'h33, 8'h59, 1'b0, 4'd1, 8'h00};
    vecs[14] = '{3'd0, 8'h00, 8'hFF, 1'b0, 4'd2, 8'hFF};
    vecs[15] = '{3'd2, 8'h00, 8'h00, 1'b1, 4'd3, 8'hFF};
    vecs[16] = '{3'd1, 8'h00, 8'h59, 1'b0, 4'd2, 8'h00};
    vecs[17] = '{3'd7, 8'h00, 8'h59, 1'b0, 4'd1, 8'h00};

    init_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00; busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ptr", {24'd0, ptr}, 32'h0);
    chk("rst_resp_data", {24'd0, resp_data}, 32'h0);
    chk("rst_resp_zero", {31'd0, resp_zero}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_doit", {31'd0, doit}, 32'd0);
    chk("rst_wselect", {31'd0, wselect}, 32'd0);
    chk("rst_addr", {24'd0, addr}, 32'h0);
    chk("rst_wdata", {24'd0, wdata}, 32'h0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    init_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_cmd(vecs[i].op, vecs[i].data, lat, rd, rz, rp);
      chk($sformatf("v%0d_data", i), {24'd0, rd}, {24'd0, vecs[i].exp_d});
      chk($sformatf("v%0d_zero", i), {31'd0, rz}, {31'd0, vecs[i].exp_z});
      chk($sformatf("v%0d_lat", i), lat, {28'd0, vecs[i].exp_lat});
      chk($sformatf("v%0d_ptr", i), {24'd0, rp}, {24'd0, vecs[i].exp_ptr});
    end
    chk("mem0", {24'd0, mem[0]}, 32'h59);
    chk("mem1", {24'd0, mem[1]}, 32'hA5);
    chk("mem255", {24'd0, mem[255]}, 32'h00);
    chk("write_count", wr_count, 32'd8);

    // INC at ptr 0 with the write held off by busy for four cycles.
    wc0 = wr_count;
    @(negedge clk);
    cmd_op = 3'd2; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_op = 3'd5;
    lat = 0; w = 0; a0 = 8'h00; d0 = 8'h00;
    do begin
      @(negedge clk);
      lat++;
      if (doit && wselect) begin
        if (w == 0) begin
          a0 = addr;
          d0 = wdata;
          chk("busy_addr", {24'd0, addr}, 32'h00);
          chk("busy_wdata", {24'd0, wdata}, 32'h5A);
        end else begin
          chk("busy_addr_stable", {24'd0, addr}, {24'd0, a0});
          chk("busy_wdata_stable", {24'd0, wdata}, {24'd0, d0});
        end
        busy = (w < 4);
        w++;
      end else begin
        busy = 1'b0;
      end
    end while (!resp_valid && lat < 40);
    busy = 1'b0;
    chk("busy_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("busy_lat", lat, 32'd7);
    chk("busy_resp_data", {24'd0, resp_data}, 32'h5A);
    chk("busy_wselect_cycles", w, 32'd5);
    chk("busy_single_write", wr_count - wc0, 32'd1);
    chk("busy_mem0", {24'd0, mem[0]}, 32'h5A);

    // Reset in the cycle after an INC is accepted at ptr 1.
    run_cmd(3'd1, 8'h00, lat, rd, rz, rp);
    chk("pre_rst_ptr", {24'd0, rp}, 32'h01);
    wc0 = wr_count;
    @(negedge clk);
    cmd_op = 3'd2; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    init_n = 1'b0;
    @(negedge clk);
    chk("abort_doit", {31'd0, doit}, 32'd0);
    chk("abort_ptr", {24'd0, ptr}, 32'h00);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    init_n = 1'b1;
    w = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid || doit) w++;
    end
    chk("abort_quiet", w, 32'd0);
    chk("abort_no_write", wr_count - wc0, 32'd0);
    chk("abort_mem1", {24'd0, mem[1]}, 32'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
